// File: rtl/exec_cond_stage.sv
`default_nettype none
// ============================================================================
// exec_cond_stage : ARM condition check, NZCV update, execute/memory register
// Revision 1.0
// ============================================================================
module exec_cond_stage #(
  parameter int BITS = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [3:0]      CondE,
  input  logic [1:0]      FlagWriteE,
  input  logic [3:0]      ALUFlags,
  input  logic            PCSrcE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            NoWriteE,
  input  logic [3:0]      WA3E,
  input  logic [BITS-1:0] ALUResultE,
  input  logic [BITS-1:0] WriteDataE,
  input  logic            STALL,
  input  logic            FLUSH,
  output logic [3:0]      Flags,
  output logic            CondExE,
  output logic            BranchTakenE,
  output logic            PCSrcM,
  output logic            RegWriteM,
  output logic            MemtoRegM,
  output logic            MemWriteM,
  output logic [3:0]      WA3M,
  output logic [BITS-1:0] ALUResultM,
  output logic [BITS-1:0] WriteDataM
);

  logic [3:0]      flags_q, flags_d;
  logic            pcsrc_q, pcsrc_d;
  logic            regwrite_q, regwrite_d;
  logic            memtoreg_q, memtoreg_d;
  logic            memwrite_q, memwrite_d;
  logic [3:0]      wa3_q, wa3_d;
  logic [BITS-1:0] result_q, result_d;
  logic [BITS-1:0] wdata_q, wdata_d;

  logic w_n, w_z, w_c, w_v, w_cond;

  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    w_cond = 1'b1;
    case (CondE)
      4'd0:    w_cond = w_z;
      4'd1:    w_cond = ~w_z;
      4'd2:    w_cond = w_c;
      4'd3:    w_cond = ~w_c;
      4'd4:    w_cond = w_n;
      4'd5:    w_cond = ~w_n;
      4'd6:    w_cond = w_v;
      4'd7:    w_cond = ~w_v;
      4'd8:    w_cond = w_c & ~w_z;
      4'd9:    w_cond = ~w_c | w_z;
      4'd10:   w_cond = (w_n == w_v);
      4'd11:   w_cond = (w_n != w_v);
      4'd12:   w_cond = ~w_z & (w_n == w_v);
      4'd13:   w_cond = w_z | (w_n != w_v);
      default: w_cond = 1'b1;
    endcase
  end

  assign CondExE      = w_cond;
  assign BranchTakenE = BranchE & w_cond;

  // FLUSH inserts a bubble and blocks flag writes; STALL freezes everything.
  always_comb begin
    flags_d    = flags_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    wa3_d      = wa3_q;
    result_d   = result_q;
    wdata_d    = wdata_q;
    if (FLUSH) begin
      pcsrc_d    = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      wa3_d      = '0;
      result_d   = '0;
      wdata_d    = '0;
    end else if (!STALL) begin
      pcsrc_d    = PCSrcE & w_cond;
      regwrite_d = RegWriteE & w_cond & ~NoWriteE;
      memtoreg_d = MemtoRegE;
      memwrite_d = MemWriteE & w_cond;
      wa3_d      = WA3E;
      result_d   = ALUResultE;
      wdata_d    = WriteDataE;
      if (FlagWriteE[1] && w_cond) flags_d[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0] && w_cond) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags_q    <= '0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      wa3_q      <= '0;
      result_q   <= '0;
      wdata_q    <= '0;
    end else begin
      flags_q    <= flags_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      wa3_q      <= wa3_d;
      result_q   <= result_d;
      wdata_q    <= wdata_d;
    end
  end

  assign Flags      = flags_q;
  assign PCSrcM     = pcsrc_q;
  assign RegWriteM  = regwrite_q;
  assign MemtoRegM  = memtoreg_q;
  assign MemWriteM  = memwrite_q;
  assign WA3M       = wa3_q;
  assign ALUResultM = result_q;
  assign WriteDataM = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_cond_stage.sv
`default_nettype none
// Testbench for exec_cond_stage: directed plan steps plus randomized traffic
// against a behavioural model of the flags register and EM pipeline register.
module tb_exec_cond_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  CondE, ALUFlags, WA3E;
  logic [1:0]  FlagWriteE;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE;
  logic [31:0] ALUResultE, WriteDataE;
  logic        STALL, FLUSH;
  logic [3:0]  Flags, WA3M;
  logic        CondExE, BranchTakenE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0]  mf;
  logic        m_pcsrc, m_regw, m_m2r, m_memw;
  logic [3:0]  m_wa3;
  logic [31:0] m_res, m_wd;

  exec_cond_stage #(.BITS(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .CondE(CondE), .FlagWriteE(FlagWriteE),
    .ALUFlags(ALUFlags), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .NoWriteE(NoWriteE), .WA3E(WA3E), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .STALL(STALL), .FLUSH(FLUSH), .Flags(Flags),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  always #5 CLK = ~CLK;

  // Condition codes come in complementary pairs: even code is the base test,
  // odd code its inverse; code 14 and 15 always pass.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mf = 4'h0; m_pcsrc = 0; m_regw = 0; m_m2r = 0; m_memw = 0;
    m_wa3 = 4'h0; m_res = 32'h0; m_wd = 32'h0;
  endtask

  task automatic check_m();
    chk("Flags", {28'h0, Flags}, {28'h0, mf});
    chk("PCSrcM", {31'h0, PCSrcM}, {31'h0, m_pcsrc});
    chk("RegWriteM", {31'h0, RegWriteM}, {31'h0, m_regw});
    chk("MemtoRegM", {31'h0, MemtoRegM}, {31'h0, m_m2r});
    chk("MemWriteM", {31'h0, MemWriteM}, {31'h0, m_memw});
    chk("WA3M", {28'h0, WA3M}, {28'h0, m_wa3});
    chk("ALUResultM", ALUResultM, m_res);
    chk("WriteDataM", WriteDataM, m_wd);
  endtask

  task automatic zero_inputs();
    CondE = 4'd14; FlagWriteE = 2'b00; ALUFlags = 4'h0; PCSrcE = 0; RegWriteE = 0;
    MemtoRegE = 0; MemWriteE = 0; BranchE = 0; NoWriteE = 0; WA3E = 4'h0;
    ALUResultE = 32'h0; WriteDataE = 32'h0; STALL = 0; FLUSH = 0;
  endtask

  // Checks combinational outputs, clocks once, updates the model, checks M stage.
  task automatic cycle();
    logic ce;
    #1;
    ce = cond_ok(CondE, mf);
    chk("CondExE", {31'h0, CondExE}, {31'h0, ce});
    chk("BranchTakenE", {31'h0, BranchTakenE}, {31'h0, BranchE && ce});
    if (FLUSH) begin
      m_pcsrc = 0; m_regw = 0; m_m2r = 0; m_memw = 0; m_wa3 = 0; m_res = 0; m_wd = 0;
    end else if (!STALL) begin
      m_pcsrc = PCSrcE && ce;
      m_regw  = RegWriteE && ce && !NoWriteE;
      m_m2r   = MemtoRegE;
      m_memw  = MemWriteE && ce;
      m_wa3   = WA3E;
      m_res   = ALUResultE;
      m_wd    = WriteDataE;
      if (ce && FlagWriteE[1]) mf[3:2] = ALUFlags[3:2];
      if (ce && FlagWriteE[0]) mf[1:0] = ALUFlags[1:0];
    end
    @(posedge CLK);
    #1;
    check_m();
  endtask

  task automatic rand_inputs(input int stall_pct, input int flush_pct);
    CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlags = 4'($urandom);
    PCSrcE = 1'($urandom); RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom);
    MemWriteE = 1'($urandom); BranchE = 1'($urandom); NoWriteE = 1'($urandom);
    WA3E = 4'($urandom); ALUResultE = $urandom; WriteDataE = $urandom;
    STALL = ($urandom_range(99) < stall_pct);
    FLUSH = ($urandom_range(99) < flush_pct);
  endtask

  initial begin
    // Reset with every input high
    RST_N = 0;
    CondE = 4'hF; FlagWriteE = 2'b11; ALUFlags = 4'hF; PCSrcE = 1; RegWriteE = 1;
    MemtoRegE = 1; MemWriteE = 1; BranchE = 1; NoWriteE = 1; WA3E = 4'hF;
    ALUResultE = 32'hFFFF_FFFF; WriteDataE = 32'hFFFF_FFFF; STALL = 1; FLUSH = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_m();
    CondE = 4'd0; #1; chk("reset_EQ", {31'h0, CondExE}, 32'h0);
    CondE = 4'd1; #1; chk("reset_NE", {31'h0, CondExE}, 32'h1);
    zero_inputs();
    @(negedge CLK);
    RST_N = 1;
    @(posedge CLK); #1;

    // Full flag write then EQ-conditional instruction
    CondE = 4'd14; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
    cycle();
    chk("flags_0100", {28'h0, Flags}, 32'h4);
    zero_inputs();
    CondE = 4'd0; RegWriteE = 1; WA3E = 4'd5; ALUResultE = 32'h1234;
    cycle();
    chk("eq_regwrite", {31'h0, RegWriteM}, 32'h1);
    chk("eq_result", ALUResultM, 32'h0000_1234);

    // Partial C,V write
    zero_inputs(); FlagWriteE = 2'b11; ALUFlags = 4'h0; cycle();
    zero_inputs(); FlagWriteE = 2'b01; ALUFlags = 4'hF; cycle();
    chk("flags_0011", {28'h0, Flags}, 32'h3);
    zero_inputs();
    CondE = 4'd8;  #1; chk("HI_pass", {31'h0, CondExE}, 32'h1);
    CondE = 4'd10; #1; chk("GE_fail", {31'h0, CondExE}, 32'h0);

    // Condition failure suppresses writes and flag update
    zero_inputs(); FlagWriteE = 2'b11; ALUFlags = 4'h0; cycle();
    CondE = 4'd0; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1; BranchE = 1;
    FlagWriteE = 2'b11; ALUFlags = 4'hF;
    #1; chk("fail_branch", {31'h0, BranchTakenE}, 32'h0);
    cycle();
    chk("fail_flags", {28'h0, Flags}, 32'h0);
    chk("fail_regw", {31'h0, RegWriteM}, 32'h0);
    zero_inputs(); CondE = 4'd14; RegWriteE = 1; NoWriteE = 1; cycle();
    chk("nowrite", {31'h0, RegWriteM}, 32'h0);

    // Stall three cycles, then flush with stall
    zero_inputs(); ALUResultE = 32'hAAAA_5555; WA3E = 4'd9; RegWriteE = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(0, 0); STALL = 1; FlagWriteE = 2'b11; CondE = 4'd14;
      cycle();
      chk("stall_hold", ALUResultM, 32'hAAAA_5555);
    end
    rand_inputs(0, 0); STALL = 1; FLUSH = 1; FlagWriteE = 2'b11; CondE = 4'd14;
    cycle();
    chk("flush_res", ALUResultM, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(15, 10);
      cycle();
    end

    // Async reset between edges
    rand_inputs(0, 0); CondE = 4'd14; FlagWriteE = 2'b11; ALUFlags = 4'hF;
    ALUResultE = 32'hDEAD_BEEF; RegWriteE = 1;
    cycle();
    #2 RST_N = 0;
    model_reset();
    #1; check_m();
    #2 zero_inputs();
    @(negedge CLK); RST_N = 1;
    @(posedge CLK); #1;
    for (int i = 0; i < 50; i++) begin
      rand_inputs(20, 10);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_cond_stage.md
# exec_cond_stage

Execute-stage consumer of the decode/execute pipeline register: evaluates the 4-bit ARM condition field against the architectural flags register, gates the write/branch controls, updates NZCV, and registers surviving results into the execute/memory (EM) pipeline register. Sits between the DE register plus ALU outputs and the memory stage; the hazard unit drives its STALL/FLUSH inputs.

## Interface
- BITS, 32, datapath width of ALU result and store data
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- CondE  in  4  condition field of instruction in E
- FlagWriteE  in  2  [1] enables N,Z write; [0] enables C,V write
- ALUFlags  in  4  ALU result flags {N,Z,C,V}
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE  in  1 each  E-stage controls
- WA3E  in  4  destination register
- ALUResultE, WriteDataE  in  BITS  ALU result, store data
- STALL  in  1  hold EM register and flags
- FLUSH  in  1  discard E instruction, insert bubble into M
- Flags  out  4  current flags register {N,Z,C,V}
- CondExE  out  1  combinational condition-pass for E instruction
- BranchTakenE  out  1  combinational BranchE & CondExE
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered gated controls
- WA3M  out  4  registered destination
- ALUResultM, WriteDataM  out  BITS  registered data

## Operation
- Flags bit order: [3]=N, [2]=Z, [1]=C, [0]=V.
- CondExE from Flags (pre-update value) and CondE: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 treated as 1.
- Gating: PCSrc = PCSrcE&CondExE; RegWrite = RegWriteE&CondExE&!NoWriteE; MemWrite = MemWriteE&CondExE; MemtoReg passes ungated.
- Flags write: Flags[3:2] <= ALUFlags[3:2] when FlagWriteE[1]&CondExE; Flags[1:0] <= ALUFlags[1:0] when FlagWriteE[0]&CondExE; both only in cycles with !STALL & !FLUSH.
- Priority per clock edge: RST_N low > FLUSH > STALL > normal load.
- FLUSH: all EM outputs (controls, WA3M, data) load 0; Flags unchanged.
- STALL (without FLUSH): all EM outputs and Flags hold.
- Normal: EM outputs load gated controls, WA3E, ALUResultE, WriteDataE.
- CondExE, BranchTakenE are combinational and valid regardless of STALL/FLUSH; hazard unit owns their qualification.

## Timing
- Reset (asynchronous, RST_N=0): Flags=4'b0000, all registered outputs 0; release takes effect on next rising CLK.
- After reset Z=0, so EQ fails and NE passes until flags written.
- EM latency: 1 cycle, E inputs at edge n visible on M outputs after edge n.
- Flags written at edge n are used by CondExE from cycle n+1; an instruction never sees its own flag update.
- Back-to-back flag-setting then conditional instruction: second uses first's flags, no bubble required.
- STALL held k cycles: outputs and Flags constant k cycles; resume loads current E inputs.
- STALL and FLUSH together: FLUSH wins.
- RST_N asserted mid-stall or mid-flush: immediate clear, no pending state retained.

## Test plan
- Reset: RST_N=0 with all inputs 1 -> Flags=0000, all M outputs 0; CondE=0 gives CondExE=0, CondE=1 gives 1.
- Flag write: CondE=14, FlagWriteE=2'b11, ALUFlags=4'b0100, edge -> Flags=0100; next CondE=0 RegWriteE=1 WA3E=5 ALUResultE=0x1234 -> RegWriteM=1, WA3M=5, ALUResultM=0x00001234.
- Partial write: Flags=0000, FlagWriteE=2'b01, ALUFlags=4'b1111 -> Flags=0011; CondE=8 (HI) -> CondExE=1; CondE=10 (GE) with Flags=0011 -> 0.
- Condition fail: Flags=0000, CondE=0, RegWriteE=MemWriteE=PCSrcE=BranchE=1, FlagWriteE=11, ALUFlags=1111 -> BranchTakenE=0, RegWriteM=MemWriteM=PCSrcM=0, Flags stays 0000; NoWriteE=1 CondE=14 RegWriteE=1 -> RegWriteM=0.
- Stall/flush: load ALUResultE=0xAAAA5555, then STALL=1 3 cycles with new inputs and FlagWriteE=11 -> ALUResultM and Flags unchanged; FLUSH=1 with STALL=1 -> all M outputs 0, Flags unchanged.
- Async reset mid-operation: RST_N low between edges -> outputs clear before next edge.
